count_seq_checker: RTL and testbench

Receive-side checker for the free-running 2-bit wrap-around count stream (0,1,2,3,0,…) produced by the counter block. It samples a count bus under a valid strobe, hunts and locks onto the sequence, flags every skip or repeat, and keeps a saturating error tally. It sits at the far end of any link carrying the counter value and acts as a built-in self-test monitor.

---
 rtl/count_seq_checker.sv | 151 +++++++++++++++
 tb/tb_count_seq_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// ============================================================================
// Module   : count_seq_checker
// Purpose  : Hunts, locks onto and monitors a 2-bit wrap-around count stream,
//            flagging skips/repeats with a saturating error tally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_checker #(
   parameter int ERR_W  = 8,
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       in_count,
   input  logic             err_clr,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       expected
);

   localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
   localparam int BW = (LOSS_N < 1) ? 1 : $clog2(LOSS_N + 1);

   localparam logic [GW-1:0]    C_LOCK_N  = GW'(LOCK_N);
   localparam logic [BW-1:0]    C_LOSS_N  = BW'(LOSS_N);
   localparam logic [GW-1:0]    C_GOOD_1  = GW'(1);
   localparam logic [ERR_W-1:0] C_ERR_ONE = ERR_W'(1);
   localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_locked;
   logic             r_err_pulse;
   logic             r_wrap_pulse;
   logic [ERR_W-1:0] r_err_count;
   logic [1:0]       r_expected;
   logic [GW-1:0]    r_good_cnt;
   logic [BW-1:0]    r_bad_cnt;

   logic             w_match;
   logic             w_err_event;
   logic [1:0]       w_resync;
   logic [1:0]       w_advance;
   logic [GW-1:0]    w_good_inc;
   logic [BW-1:0]    w_bad_inc;
   logic [ERR_W-1:0] w_err_inc;

   assign w_match     = in_valid && (in_count == r_expected);
   assign w_err_event = in_valid && (r_state == ST_LOCKED) && !w_match;
   assign w_resync    = in_count + 2'd1;
   assign w_advance   = r_expected + 2'd1;
   assign w_good_inc  = r_good_cnt + C_GOOD_1;
   assign w_bad_inc   = r_bad_cnt + BW'(1);
   assign w_err_inc   = (r_err_count == C_ERR_MAX) ? r_err_count
                                                   : r_err_count + C_ERR_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_HUNT;
         r_locked     <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_err_count  <= '0;
         r_expected   <= 2'b00;
         r_good_cnt   <= '0;
         r_bad_cnt    <= '0;
      end else begin
         r_err_pulse  <= 1'b0;
         r_wrap_pulse <= 1'b0;

         if (in_valid) begin
            case (r_state)
               ST_HUNT: begin
                  r_expected <= w_resync;
                  r_good_cnt <= C_GOOD_1;
                  if (LOCK_N <= 1) begin
                     r_state   <= ST_LOCKED;
                     r_locked  <= 1'b1;
                     r_bad_cnt <= '0;
                  end else begin
                     r_state <= ST_SYNC;
                  end
               end

               ST_SYNC: begin
                  if (w_match) begin
                     r_expected <= w_advance;
                     r_good_cnt <= w_good_inc;
                     if (w_good_inc >= C_LOCK_N) begin
                        r_state   <= ST_LOCKED;
                        r_locked  <= 1'b1;
                        r_bad_cnt <= '0;
                     end
                  end else begin
                     // Restart the run from the value just seen; no error while unlocked.
                     r_expected <= w_resync;
                     r_good_cnt <= C_GOOD_1;
                  end
               end

               ST_LOCKED: begin
                  if (w_match) begin
                     r_expected   <= w_advance;
                     r_bad_cnt    <= '0;
                     r_wrap_pulse <= (in_count == 2'd3);
                  end else begin
                     r_err_pulse <= 1'b1;
                     r_expected  <= w_resync;
                     r_bad_cnt   <= w_bad_inc;
                     if (w_bad_inc >= C_LOSS_N) begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                     end
                  end
               end

               default: begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
               end
            endcase
         end

         // A clear coinciding with an error keeps that error counted.
         if (err_clr) begin
            r_err_count <= w_err_event ? C_ERR_ONE : '0;
         end else if (w_err_event) begin
            r_err_count <= w_err_inc;
         end
      end
   end

   assign locked     = r_locked;
   assign err_pulse  = r_err_pulse;
   assign wrap_pulse = r_wrap_pulse;
   assign err_count  = r_err_count;
   assign expected   = r_expected;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// Module   : tb_count_seq_checker
// Purpose  : Directed-vector scoreboard bench for count_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

   logic clk;

   // Instance A: ERR_W=8, LOCK_N=4, LOSS_N=2
   logic       a_rst, a_valid, a_clr;
   logic [1:0] a_count;
   logic       a_locked, a_err, a_wrap;
   logic [7:0] a_errcnt;
   logic [1:0] a_exp;

   // Instance B: ERR_W=2, LOCK_N=1, LOSS_N=8 (saturation and single-sample lock)
   logic       b_rst, b_valid, b_clr;
   logic [1:0] b_count;
   logic       b_locked, b_err, b_wrap;
   logic [1:0] b_errcnt;
   logic [1:0] b_exp;

   count_seq_checker #(.ERR_W(8), .LOCK_N(4), .LOSS_N(2)) u_dut_a (
      .clk        (clk),
      .rst        (a_rst),
      .in_valid   (a_valid),
      .in_count   (a_count),
      .err_clr    (a_clr),
      .locked     (a_locked),
      .err_pulse  (a_err),
      .wrap_pulse (a_wrap),
      .err_count  (a_errcnt),
      .expected   (a_exp)
   );

   count_seq_checker #(.ERR_W(2), .LOCK_N(1), .LOSS_N(8)) u_dut_b (
      .clk        (clk),
      .rst        (b_rst),
      .in_valid   (b_valid),
      .in_count   (b_count),
      .err_clr    (b_clr),
      .locked     (b_locked),
      .err_pulse  (b_err),
      .wrap_pulse (b_wrap),
      .err_count  (b_errcnt),
      .expected   (b_exp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entry layout: {sel, locked, err_pulse, wrap_pulse, err_count[7:0], expected[1:0]}
   logic [13:0] exp_q[$];
   string       tag_q[$];
   int          errors = 0;
   int          checks = 0;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [13:0] want;
         logic [12:0] got;
         string       tag;
         want = exp_q.pop_front();
         tag  = tag_q.pop_front();
         if (want[13])
            got = {b_locked, b_err, b_wrap, 6'd0, b_errcnt, b_exp};
         else
            got = {a_locked, a_err, a_wrap, a_errcnt, a_exp};
         checks++;
         if (got !== want[12:0]) begin
            errors++;
            $display("FAIL %s: got locked=%b err=%b wrap=%b cnt=%0d exp=%0d, want locked=%b err=%b wrap=%b cnt=%0d exp=%0d",
                     tag, got[12], got[11], got[10], got[9:2], got[1:0],
                     want[12], want[11], want[10], want[9:2], want[1:0]);
         end
      end
   end

   // Drive one cycle of stimulus on DUT sel and queue its hand-computed response.
   task automatic step(input bit sel, input bit r, input bit v, input logic [1:0] c,
                       input bit clr, input bit l, input bit e, input bit w,
                       input int cnt, input logic [1:0] x, input string tag);
      @(negedge clk);
      if (sel) begin
         b_rst = r; b_valid = v; b_count = c; b_clr = clr;
      end else begin
         a_rst = r; a_valid = v; a_count = c; a_clr = clr;
      end
      exp_q.push_back({sel, l, e, w, 8'(cnt), x});
      tag_q.push_back(tag);
   endtask

   initial begin
      a_rst = 1'b1; a_valid = 1'b0; a_count = 2'd0; a_clr = 1'b0;
      b_rst = 1'b1; b_valid = 1'b0; b_count = 2'd0; b_clr = 1'b0;

      //      sel r v cnt clr  l e w cnt exp
      step(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, "reset0");
      step(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, "reset1");

      // Acquire: four in-sequence samples lock on the fourth.
      step(0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, "acq0");
      step(0, 0, 1, 2'd1, 0, 0, 0, 0, 0, 2'd2, "acq1");
      step(0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 2'd3, "acq2");
      step(0, 0, 1, 2'd3, 0, 1, 0, 0, 0, 2'd0, "acq3_lock");

      // 20 locked samples: wrap only on value 3.
      for (int i = 0; i < 20; i++) begin
         logic [1:0] val;
         val = 2'(i);
         step(0, 0, 1, val, 0, 1, 0, (val == 2'd3), 0, val + 2'd1, "stream");
      end

      // Skip: expected=2, send 3 then 0,1.
      step(0, 0, 1, 2'd0, 0, 1, 0, 0, 0, 2'd1, "pre0");
      step(0, 0, 1, 2'd1, 0, 1, 0, 0, 0, 2'd2, "pre1");
      step(0, 0, 1, 2'd3, 0, 1, 1, 0, 1, 2'd0, "skip_err");
      step(0, 0, 1, 2'd0, 0, 1, 0, 0, 1, 2'd1, "skip_rec0");
      step(0, 0, 1, 2'd1, 0, 1, 0, 0, 1, 2'd2, "skip_rec1");

      // err_clr alone clears the tally, nothing else moves.
      step(0, 0, 0, 2'd3, 1, 1, 0, 0, 0, 2'd2, "clr_alone");

      // Two consecutive mismatches (skip then repeat) drop lock.
      step(0, 0, 1, 2'd3, 0, 1, 1, 0, 1, 2'd0, "loss1");
      step(0, 0, 1, 2'd3, 0, 0, 1, 0, 2, 2'd0, "loss2_unlock");
      step(0, 0, 1, 2'd0, 0, 0, 0, 0, 2, 2'd1, "relock0");
      step(0, 0, 1, 2'd1, 0, 0, 0, 0, 2, 2'd2, "relock1");
      step(0, 0, 1, 2'd2, 0, 0, 0, 0, 2, 2'd3, "relock2");
      step(0, 0, 1, 2'd3, 0, 1, 0, 0, 2, 2'd0, "relock3");

      // Gaps in in_valid are transparent; idle count value is ignored.
      for (int s = 0; s < 4; s++) begin
         logic [1:0] val;
         val = 2'(s);
         step(0, 0, 1, val, 0, 1, 0, (val == 2'd3), 2, val + 2'd1, "gap_sample");
         for (int g = 0; g < 3; g++)
            step(0, 0, 0, 2'd2, 0, 1, 0, 0, 2, val + 2'd1, "gap_idle");
      end

      // Reset mid-stream with a valid sample present.
      step(0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, "mid_reset");

      // SYNC mismatch restarts the run without counting an error.
      step(0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, "sync_h0");
      step(0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 2'd3, "sync_miss");
      step(0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 2'd0, "sync_g2");
      step(0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, "sync_g3");
      step(0, 0, 1, 2'd1, 0, 1, 0, 0, 0, 2'd2, "sync_lock");
      step(0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 2'd2, "a_idle");

      // Instance B: lock on one sample, saturate at 3, clear on error gives 1.
      step(1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, "b_reset");
      step(1, 0, 1, 2'd2, 0, 1, 0, 0, 0, 2'd3, "b_lock1");
      step(1, 0, 1, 2'd2, 0, 1, 1, 0, 1, 2'd3, "b_err1");
      step(1, 0, 1, 2'd2, 0, 1, 1, 0, 2, 2'd3, "b_err2");
      step(1, 0, 1, 2'd2, 0, 1, 1, 0, 3, 2'd3, "b_err3");
      step(1, 0, 1, 2'd2, 0, 1, 1, 0, 3, 2'd3, "b_sat4");
      step(1, 0, 1, 2'd2, 0, 1, 1, 0, 3, 2'd3, "b_sat5");
      step(1, 0, 1, 2'd2, 1, 1, 1, 0, 1, 2'd3, "b_clr_err");
      step(1, 0, 1, 2'd3, 0, 1, 0, 1, 1, 2'd0, "b_wrap");
      step(1, 0, 1, 2'd0, 1, 1, 0, 0, 0, 2'd1, "b_clr_match");
      step(1, 0, 0, 2'd0, 0, 1, 0, 0, 0, 2'd1, "b_idle");

      for (int t = 0; t < 10 && exp_q.size() > 0; t++)
         @(posedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
